// File: rtl/i2c_slave_rx_if.sv
// Bus-side and fabric-side signal bundle for the I2C target receiver.
interface i2c_slave_rx_if;
   logic       scl_in;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_rw;
   logic       addr_hit;
   logic       stop_det;
   logic [2:0] state;

   modport slave (
      input  scl_in, sda_in,
      output sda_oe, rx_data, rx_valid, rx_rw,
      output addr_hit, stop_det, state
   );

   modport master (
      output scl_in, sda_in,
      input  sda_oe, rx_data, rx_valid, rx_rw,
      input  addr_hit, stop_det, state
   );
endinterface

// File: rtl/i2c_slave_rx.sv
// I2C target receiver: oversampled START/STOP detect, 7-bit address
// match, ACK drive and per-byte delivery with a one-cycle strobe.
module i2c_slave_rx #(
   parameter logic [6:0] SLAVE_ADDR  = 7'h32,
   parameter int         SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          reset,
   i2c_slave_rx_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      ACK_A  = 3'd2,
      DATA   = 3'd3,
      ACK_D  = 3'd4,
      IGNORE = 3'd5
   } state_t;

   logic [SYNC_STAGES-1:0] r_scl_sync;
   logic [SYNC_STAGES-1:0] r_sda_sync;
   logic                   r_scl_p;
   logic                   r_sda_p;

   logic w_scl_s;
   logic w_sda_s;
   logic w_scl_rise;
   logic w_scl_fall;
   logic w_start;
   logic w_stop;
   logic w_byte_done;

   state_t     r_state;
   logic [3:0] r_cnt;
   logic [7:0] r_shift;
   logic [7:0] r_rx_data;
   logic       r_sda_oe;
   logic       r_rx_valid;
   logic       r_rx_rw;
   logic       r_addr_hit;
   logic       r_stop_det;

   // Reset to ones so an idle bus never looks like an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_scl_sync <= '1;
         r_sda_sync <= '1;
         r_scl_p    <= 1'b1;
         r_sda_p    <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
         r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
         r_scl_p    <= w_scl_s;
         r_sda_p    <= w_sda_s;
      end
   end

   assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
   assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
   assign w_scl_rise  = w_scl_s & ~r_scl_p;
   assign w_scl_fall  = ~w_scl_s & r_scl_p;
   assign w_start     = w_scl_s & r_scl_p & r_sda_p & ~w_sda_s;
   assign w_stop      = w_scl_s & r_scl_p & ~r_sda_p & w_sda_s;
   assign w_byte_done = w_scl_fall & (r_cnt == 4'd8);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_cnt      <= 4'd0;
         r_shift    <= 8'd0;
         r_rx_data  <= 8'd0;
         r_sda_oe   <= 1'b0;
         r_rx_valid <= 1'b0;
         r_rx_rw    <= 1'b0;
         r_addr_hit <= 1'b0;
         r_stop_det <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         r_stop_det <= 1'b0;
         if (w_stop && (r_state != IDLE)) begin
            r_state    <= IDLE;
            r_sda_oe   <= 1'b0;
            r_addr_hit <= 1'b0;
            r_stop_det <= 1'b1;
         end else if (w_start) begin
            r_state    <= ADDR;
            r_cnt      <= 4'd0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_addr_hit <= 1'b0;
         end else begin
            unique case (r_state)
               IDLE: begin
               end
               ADDR: begin
                  if (w_scl_rise) begin
                     r_shift <= {r_shift[6:0], w_sda_s};
                     r_cnt   <= r_cnt + 4'd1;
                  end else if (w_byte_done) begin
                     if (r_shift[7:1] == SLAVE_ADDR) begin
                        r_rx_rw    <= r_shift[0];
                        r_sda_oe   <= 1'b1;
                        r_addr_hit <= 1'b1;
                        r_state    <= ACK_A;
                     end else begin
                        r_state <= IGNORE;
                     end
                  end
               end
               DATA: begin
                  if (w_scl_rise) begin
                     r_shift <= {r_shift[6:0], w_sda_s};
                     r_cnt   <= r_cnt + 4'd1;
                  end else if (w_byte_done) begin
                     r_rx_data  <= r_shift;
                     r_rx_valid <= 1'b1;
                     r_sda_oe   <= 1'b1;
                     r_state    <= ACK_D;
                  end
               end
               // ACK is released on the fall that ends the ninth pulse.
               ACK_A, ACK_D: begin
                  if (w_scl_fall) begin
                     r_sda_oe <= 1'b0;
                     r_cnt    <= 4'd0;
                     r_shift  <= 8'd0;
                     r_state  <= DATA;
                  end
               end
               IGNORE: begin
                  r_sda_oe <= 1'b0;
               end
               default: begin
                  r_state  <= IDLE;
                  r_sda_oe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sda_oe   = r_sda_oe;
   assign bus.rx_data  = r_rx_data;
   assign bus.rx_valid = r_rx_valid;
   assign bus.rx_rw    = r_rx_rw;
   assign bus.addr_hit = r_addr_hit;
   assign bus.stop_det = r_stop_det;
   assign bus.state    = r_state;
endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: bit-level I2C master driving directed and
// random write transactions, checked against a transaction-level model.
module tb_i2c_slave_rx;
   localparam int         Q  = 8;
   localparam logic [6:0] SA = 7'h32;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic scl_m = 1'b1;
   logic sda_m = 1'b1;

   int n_cmp    = 0;
   int n_bad    = 0;
   int stop_cnt = 0;
   logic [7:0] q_obs[$];

   i2c_slave_rx_if bus();

   assign bus.scl_in = scl_m;
   assign bus.sda_in = sda_m & ~bus.sda_oe;

   i2c_slave_rx #(
      .SLAVE_ADDR (SA),
      .SYNC_STAGES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.rx_valid) q_obs.push_back(bus.rx_data);
         if (bus.stop_det) stop_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wq(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; wq(Q);
      scl_m = 1'b1; wq(Q);
      sda_m = 1'b1; wq(2*Q);
   endtask

   task automatic clk_bit(input logic b, output logic rd);
      sda_m = b;    wq(Q);
      scl_m = 1'b1; wq(Q);
      rd = bus.sda_in;
      wq(Q);
      scl_m = 1'b0; wq(Q);
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic d;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], d);
      clk_bit(1'b1, d);
      ack = ~d;
   endtask

   logic       ack, dd, hit, rw;
   logic [6:0] a;
   logic [7:0] d[4];
   int         nb, part, acks, s0;

   initial begin
      wq(5);
      chk("rst_state", bus.state, 0);
      chk("rst_oe", bus.sda_oe, 0);
      chk("rst_data", bus.rx_data, 0);
      chk("rst_valid", bus.rx_valid, 0);
      chk("rst_rw", bus.rx_rw, 0);
      chk("rst_hit", bus.addr_hit, 0);
      chk("rst_stop", bus.stop_det, 0);
      reset = 1'b0;
      wq(4);

      // single byte, read bit set
      q_obs.delete(); s0 = stop_cnt;
      i2c_start();
      send_byte({SA, 1'b1}, ack); chk("t1_aack", ack, 1);
      send_byte(8'h0A, ack);      chk("t1_dack", ack, 1);
      chk("t1_hit", bus.addr_hit, 1);
      chk("t1_rw", bus.rx_rw, 1);
      i2c_stop();
      chk("t1_nrx", q_obs.size(), 1);
      if (q_obs.size() > 0) chk("t1_rx", q_obs[0], 8'h0A);
      chk("t1_stop", stop_cnt - s0, 1);
      chk("t1_hit_off", bus.addr_hit, 0);
      chk("t1_state", bus.state, 0);
      chk("t1_hold", bus.rx_data, 8'h0A);

      // wrong address
      q_obs.delete(); s0 = stop_cnt;
      i2c_start();
      send_byte({7'h33, 1'b0}, ack); chk("t2_aack", ack, 0);
      chk("t2_state", bus.state, 5);
      send_byte(8'hFF, ack);         chk("t2_dack", ack, 0);
      i2c_stop();
      chk("t2_nrx", q_obs.size(), 0);
      chk("t2_stop", stop_cnt - s0, 1);
      chk("t2_state0", bus.state, 0);

      // three bytes
      q_obs.delete();
      d[0] = 8'hA5; d[1] = 8'h3C; d[2] = 8'h81;
      i2c_start();
      send_byte({SA, 1'b0}, ack); chk("t3_aack", ack, 1);
      for (int i = 0; i < 3; i++) begin
         send_byte(d[i], ack); chk("t3_dack", ack, 1);
      end
      chk("t3_rw", bus.rx_rw, 0);
      i2c_stop();
      chk("t3_nrx", q_obs.size(), 3);
      for (int i = 0; i < q_obs.size() && i < 3; i++)
         chk("t3_rx", q_obs[i], d[i]);

      // partial byte then repeated START
      q_obs.delete();
      i2c_start();
      send_byte({SA, 1'b0}, ack);
      for (int i = 0; i < 4; i++) clk_bit(1'b1, dd);
      i2c_start();
      chk("t4_hit_drop", bus.addr_hit, 0);
      chk("t4_state", bus.state, 1);
      send_byte({SA, 1'b0}, ack); chk("t4_aack", ack, 1);
      chk("t4_hit_back", bus.addr_hit, 1);
      send_byte(8'h55, ack);
      i2c_stop();
      chk("t4_nrx", q_obs.size(), 1);
      if (q_obs.size() > 0) chk("t4_rx", q_obs[0], 8'h55);

      // reset during the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) clk_bit(i == 0 ? 1'b0 : SA[i-1], dd);
      sda_m = 1'b1; wq(Q);
      scl_m = 1'b1; wq(Q);
      chk("t5_oe_pre", bus.sda_oe, 1);
      chk("t5_state_pre", bus.state, 2);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk("t5_oe_async", bus.sda_oe, 0);
      wq(3);
      reset = 1'b0;
      wq(2);
      chk("t5_state", bus.state, 0);
      scl_m = 1'b0; wq(Q);
      s0 = stop_cnt;
      i2c_stop();
      chk("t5_idle_stop", stop_cnt - s0, 0);
      q_obs.delete();
      i2c_start();
      send_byte({SA, 1'b0}, ack); chk("t5_aack", ack, 1);
      send_byte(8'h0A, ack);
      i2c_stop();
      chk("t5_nrx", q_obs.size(), 1);
      if (q_obs.size() > 0) chk("t5_rx", q_obs[0], 8'h0A);

      // SCL held low mid-byte
      q_obs.delete();
      i2c_start();
      send_byte({SA, 1'b0}, ack);
      s0 = stop_cnt;
      d[0] = 8'hC3;
      for (int i = 7; i >= 4; i--) clk_bit(d[0][i], dd);
      wq(500);
      chk("t6_state", bus.state, 3);
      wq(500);
      for (int i = 3; i >= 0; i--) clk_bit(d[0][i], dd);
      clk_bit(1'b1, dd);
      chk("t6_ack", dd, 0);
      chk("t6_nostop", stop_cnt - s0, 0);
      chk("t6_nrx", q_obs.size(), 1);
      if (q_obs.size() > 0) chk("t6_rx", q_obs[0], 8'hC3);
      i2c_stop();

      // random transactions against the transaction model
      for (int t = 0; t < 24; t++) begin
         a    = ($urandom_range(0, 1) == 1) ? SA : 7'($urandom);
         rw   = 1'($urandom);
         nb   = $urandom_range(0, 3);
         part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
         q_obs.delete();
         s0   = stop_cnt;
         acks = 0;
         i2c_start();
         send_byte({a, rw}, ack); acks += int'(ack);
         for (int i = 0; i < nb; i++) begin
            send_byte(d[i], ack); acks += int'(ack);
         end
         for (int i = 0; i < part; i++) clk_bit(1'($urandom), dd);
         i2c_stop();
         hit = (a == SA);
         chk("rnd_acks", acks, hit ? nb + 1 : 0);
         chk("rnd_nrx", q_obs.size(), hit ? nb : 0);
         for (int i = 0; i < q_obs.size() && i < nb; i++)
            chk("rnd_rx", q_obs[i], d[i]);
         if (hit) chk("rnd_rw", bus.rx_rw, rw);
         chk("rnd_stop", stop_cnt - s0, 1);
         chk("rnd_state", bus.state, 0);
         chk("rnd_oe", bus.sda_oe, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
- I2C responder (target) that receives from the team's I2C master transmitter.
- Oversamples the bus SCL/SDA lines with the system clock, detects START and STOP, and matches the 7-bit address against SLAVE_ADDR.
- Drives ACK on SDA (open-drain enable) and delivers each received data byte to the fabric with a one-cycle valid strobe.
- Sits on the bus side opposite the master, inside the same system clock domain.

Parameters:
- SLAVE_ADDR, 7'h32, address this target responds to.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in; legal values 2..3.

Ports:
- clk  in  1  system clock; must be at least 8x the SCL rate.
- reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  bus SCL level, asynchronous.
- sda_in  in  1  bus SDA level, asynchronous.
- sda_oe  out  1  1 = pull SDA low (ACK); 0 = release.
- rx_data  out  8  last received data byte, MSB first on the wire.
- rx_valid  out  1  one-cycle strobe; rx_data is new.
- rx_rw  out  1  R/W bit captured in the matched address byte.
- addr_hit  out  1  high from address ACK until STOP or repeated START.
- stop_det  out  1  one-cycle strobe on a STOP condition.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async assert, sync release):
  - Synchronizer flops and previous-level flops = 1 (idle bus).
  - state = IDLE, sda_oe = 0, rx_data = 0, rx_valid = 0, rx_rw = 0, addr_hit = 0, stop_det = 0.
  - Bit counter = 0, shift register = 0.
- Conditioning:
  - scl_s and sda_s are the last synchronizer stages; scl_p and sda_p are their 1-cycle-delayed copies.
  - scl_rise = scl_s & ~scl_p; scl_fall = ~scl_s & scl_p.
  - start_c = scl_s & scl_p & sda_p & ~sda_s.
  - stop_c = scl_s & scl_p & ~sda_p & sda_s.
  - Detection latency = SYNC_STAGES+1 clk from the bus edge.
- FSM encoding: IDLE=0, ADDR=1, ACK_A=2, DATA=3, ACK_D=4, IGNORE=5.
- Global priority, highest first:
  - stop_c (not in IDLE): go to IDLE, sda_oe = 0, addr_hit = 0, stop_det = 1 for one cycle.
  - start_c (any state, including IDLE and mid-byte): go to ADDR, count = 0, shift = 0, sda_oe = 0, addr_hit = 0. This covers repeated START.
  - Then the per-state rules below.
- IDLE: wait for start_c.
- ADDR:
  - On each scl_rise, shift in sda_s MSB first and increment count.
  - On the scl_fall after the 8th bit: if shift[7:1] == SLAVE_ADDR, then rx_rw = shift[0], sda_oe = 1, addr_hit = 1, go to ACK_A. Otherwise go to IGNORE.
- ACK_A:
  - Hold sda_oe = 1 through the ACK clock pulse.
  - On the next scl_fall: sda_oe = 0, count = 0, go to DATA.
- DATA:
  - Shift on scl_rise, same as ADDR.
  - On the scl_fall after the 8th bit: rx_data = shift, rx_valid = 1 for exactly one cycle, sda_oe = 1, go to ACK_D.
- ACK_D:
  - On the next scl_fall: sda_oe = 0, count = 0, return to DATA. Multi-byte writes are supported.
- IGNORE: sda_oe = 0; only START or STOP exit.
- rx_rw is informational only: the block always receives and ACKs regardless of rx_rw. A read-direction responder is out of scope.
- Boundaries:
  - STOP or START arriving mid-byte discards the partial byte; no rx_valid is issued.
  - SCL held low indefinitely: state and sda_oe hold; there is no timeout.
  - A STOP while in IDLE produces no stop_det.
  - rx_data holds its value until the next completed byte.
  - Reset asserted mid-transfer releases SDA immediately, since sda_oe is cleared asynchronously.

Test Plan:
- Master sequence START, addr 0110010, RW=1, data 8'h0A, STOP -> sda_oe=1 during the two ACK pulses; rx_valid exactly one pulse with rx_data=8'h0A; rx_rw=1; addr_hit high until STOP; stop_det one pulse; state returns to 0.
- START, addr 7'h33, data 8'hFF, STOP -> sda_oe never asserted; state=5 after the address byte; no rx_valid; stop_det pulses; state returns to 0.
- START, addr 7'h32 RW=0, data bytes 8'hA5, 8'h3C, 8'h81, STOP -> three rx_valid pulses in order A5, 3C, 81; an ACK after each byte; rx_rw=0.
- START, addr hit, 4 data bits of 8'hF0, repeated START, addr 7'h32, data 8'h55, STOP -> the partial byte is dropped; only rx_valid with 8'h55 occurs; addr_hit drops at the repeated START and rises again at the second address ACK.
- Assert reset while sda_oe=1 in ACK_A -> sda_oe=0 with no clock edge required; after release, state=0, and a following full transfer of 8'h0A is received correctly.
- SCL stretched low for 1000 clk between data bits 3 and 4 of 8'hC3 -> rx_data=8'hC3 received with no spurious START/STOP detected.
